instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 54 +++++
 rtl/seq_watchdog.sv | 32 +++
 rtl/instr_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the instruction sequencer: FSM states, op
// classes and the class-flag priority/legality helpers.
package seq_pkg;

  localparam int HALT_PC_DEFAULT = 128;
  localparam int WDOG_DEFAULT    = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } seqStateT;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_PUT,
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_HALT
  } opClassT;

  typedef struct packed {
    logic put;
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic halt;
  } opFlagsT;

  // Malformed decodes still execute as the strongest asserted class.
  function automatic opClassT selectOp(input opFlagsT f);
    opClassT op;
    if (f.halt)        op = OP_HALT;
    else if (f.branch) op = OP_BRANCH;
    else if (f.store)  op = OP_STORE;
    else if (f.load)   op = OP_LOAD;
    else if (f.alu)    op = OP_ALU;
    else if (f.put)    op = OP_PUT;
    else               op = OP_NOP;
    return op;
  endfunction

  function automatic logic isIllegal(input opFlagsT f);
    return ($countones(f) != 1);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-run active-cycle counter; expire rises once WDOG busy cycles have
// elapsed and stays high until the next clear.
module seq_watchdog
  import seq_pkg::*;
#(
  parameter int WDOG = WDOG_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (WDOG > 2) ? $clog2(WDOG) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WDOG - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback
// control with a run handshake, retired-instruction count and watchdog.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int D       = 12,
  parameter int HALT_PC = HALT_PC_DEFAULT,
  parameter int WDOG    = WDOG_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [D-1:0] prog_ctr,
  input  logic         op_put,
  input  logic         op_alu,
  input  logic         op_load,
  input  logic         op_store,
  input  logic         op_branch,
  input  logic         op_halt,
  input  logic         branch_cond,
  output logic         ir_load,
  output logic         acc_put,
  output logic         flags_en,
  output logic         reg_we,
  output logic         mem_we,
  output logic         pc_advance,
  output logic         pc_jump,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         illegal,
  output logic [15:0]  instr_count
);

  seqStateT    state;
  opClassT     opQ;
  logic        condQ;
  logic        timeoutQ;
  logic        illegalQ;
  logic [15:0] countQ;
  logic        expire;
  logic        start;
  logic        atHalt;
  opFlagsT     flags;

  assign flags  = '{put: op_put, alu: op_alu, load: op_load,
                    store: op_store, branch: op_branch, halt: op_halt};
  assign atHalt = (prog_ctr == D'(HALT_PC));
  assign start  = (state == S_IDLE) && req;
  assign busy   = (state != S_IDLE) && (state != S_DONE);

  seq_watchdog #(
    .WDOG(WDOG)
  ) uWatchdog (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .enable(busy),
    .expire(expire)
  );

  // Strobe decode from state and latched op/cond; the fetch strobe is
  // suppressed on the terminating fetch so no instruction is loaded.
  always_comb begin
    ir_load    = 1'b0;
    acc_put    = 1'b0;
    flags_en   = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    pc_advance = 1'b0;
    pc_jump    = 1'b0;
    unique case (state)
      S_FETCH: ir_load = !atHalt;
      S_EXEC: begin
        unique case (opQ)
          OP_PUT: begin
            acc_put    = 1'b1;
            pc_advance = 1'b1;
          end
          OP_STORE: begin
            mem_we     = 1'b1;
            pc_advance = 1'b1;
          end
          OP_BRANCH: begin
            pc_jump    = condQ;
            pc_advance = !condQ;
          end
          OP_ALU:  flags_en   = 1'b1;
          OP_NOP:  pc_advance = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_advance = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      opQ      <= OP_NOP;
      condQ    <= 1'b0;
      timeoutQ <= 1'b0;
      illegalQ <= 1'b0;
      countQ   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_FETCH;
            countQ   <= '0;
            timeoutQ <= 1'b0;
            illegalQ <= 1'b0;
          end
        end
        S_FETCH:  state <= atHalt ? S_DONE : S_DECODE;
        S_DECODE: begin
          opQ   <= selectOp(flags);
          condQ <= branch_cond;
          if (isIllegal(flags)) illegalQ <= 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (opQ)
            OP_ALU:  state <= S_WB;
            OP_LOAD: state <= S_MEM;
            OP_HALT: state <= S_DONE;
            default: state <= S_FETCH;
          endcase
        end
        S_MEM:  state <= S_WB;
        S_WB:   state <= S_FETCH;
        S_DONE: if (!req) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Watchdog expiry wins over whatever the active state chose.
      if (busy && expire) begin
        state    <= S_DONE;
        timeoutQ <= 1'b1;
      end

      if ((pc_advance || pc_jump) && (countQ != 16'hFFFF)) begin
        countQ <= countQ + 16'd1;
      end
    end
  end

  assign done        = (state == S_DONE);
  assign timeout     = timeoutQ;
  assign illegal     = illegalQ;
  assign instr_count = countQ;

endmodule
